// File: rtl/lsu.sv
// lsu: load/store unit between ALU and data memory with valid/ready writeback
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_size,
  input  logic [4:0]  in_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [2:0] size;
  logic [1:0] off;
  logic mem, legal, mis, err;
  logic [3:0] strb;
  logic [31:0] wdat, sh, ext;
  assign in_ready = state == IDLE;
  assign dmem_req = state == REQ;
  assign out_valid = state == DONE;
  always_comb begin
    mem = in_kind == 2'b01 || in_kind == 2'b10;
    legal = in_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    mis = (in_size[1:0] == 2'b01 && in_addr[0]) || (in_size[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
    err = mem && (!legal || mis);
    strb = in_size[1:0] == 2'b00 ? 4'b0001 << in_addr[1:0] :
           in_size[1:0] == 2'b01 ? 4'b0011 << in_addr[1:0] : 4'b1111;
    wdat = in_size[1:0] == 2'b00 ? {4{in_wdata[7:0]}} :
           in_size[1:0] == 2'b01 ? {2{in_wdata[15:0]}} : in_wdata;
    sh = dmem_rdata >> {off, 3'b000};
    ext = size[1:0] == 2'b00 ? {{24{sh[7] & ~size[2]}}, sh[7:0]} :
          size[1:0] == 2'b01 ? {{16{sh[15] & ~size[2]}}, sh[15:0]} : sh;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      size <= '0;
      off <= '0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      out_data <= '0;
      out_rd <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        state <= mem && !err ? REQ : DONE;
        size <= in_size;
        off <= in_addr[1:0];
        dmem_we <= in_kind == 2'b10;
        dmem_addr <= {in_addr[31:2], 2'b00};
        dmem_wstrb <= in_kind == 2'b10 ? strb : 4'b0000;
        dmem_wdata <= wdat;
        out_data <= in_addr;
        out_rd <= in_rd;
        out_err <= err;
      end
      if (state == REQ && dmem_resp_valid) begin
        state <= DONE;
        if (!dmem_we) out_data <= ext;
      end
      if (state == DONE && out_ready) state <= IDLE;
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a behavioural model
module tb_lsu;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic [1:0] in_kind = 0;
  logic [2:0] in_size = 0;
  logic [4:0] in_rd = 0;
  logic dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0] dmem_wstrb;
  logic dmem_resp_valid = 0;
  logic [31:0] dmem_rdata = 0;
  logic out_valid, out_ready = 1;
  logic [31:0] out_data;
  logic [4:0] out_rd;
  logic out_err;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_kind(in_kind), .in_size(in_size), .in_rd(in_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_err(out_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [1:0] k, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdw,
                                output logic go, output logic e_err, output logic [3:0] e_strb,
                                output logic [31:0] e_wd, output logic [31:0] e_out);
    int nb, o;
    logic is_mem, ok;
    longint v;
    is_mem = k == 2'd1 || k == 2'd2;
    ok = sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5;
    nb = (sz % 4 == 0) ? 1 : (sz % 4 == 1) ? 2 : 4;
    o = int'(a % 4);
    e_err = is_mem && (!ok || (o % nb) != 0);
    go = is_mem && !e_err;
    e_strb = (k == 2'd2) ? 4'(((1 << nb) - 1) << o) : 4'd0;
    for (int b = 0; b < 4; b++) e_wd[8*b +: 8] = wd[8*(b % nb) +: 8];
    e_out = a;
    if (go && k == 2'd1) begin
      v = longint'(rdw) / (longint'(1) << (8 * o)) % (longint'(1) << (8 * nb));
      if (sz < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      e_out = v[31:0];
    end
  endfunction
  task automatic run_op(input logic [1:0] k, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r, input int waits,
                        input logic [31:0] rdw, input int hold);
    logic go, e_err;
    logic [3:0] e_strb;
    logic [31:0] e_wd, e_out;
    model(k, sz, a, wd, rdw, go, e_err, e_strb, e_wd, e_out);
    chk("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1; in_kind = k; in_size = sz; in_addr = a; in_wdata = wd; in_rd = r;
    out_ready = hold == 0;
    tick();
    in_valid = 0; in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    in_kind = 2'($urandom); in_size = 3'($urandom);
    if (go) begin
      for (int w = 0; w <= waits; w++) begin
        chk("req", {31'b0, dmem_req}, 1);
        chk("req_addr", dmem_addr, {a[31:2], 2'b00});
        chk("req_we", {31'b0, dmem_we}, {31'b0, k == 2'd2});
        chk("req_strb", {28'b0, dmem_wstrb}, {28'b0, e_strb});
        if (k == 2'd2) chk("req_wdata", dmem_wdata, e_wd);
        chk("req_no_valid", {31'b0, out_valid}, 0);
        chk("req_in_ready", {31'b0, in_ready}, 0);
        if (w == waits) begin
          dmem_resp_valid = 1;
          dmem_rdata = rdw;
        end
        tick();
        dmem_resp_valid = 0;
        dmem_rdata = $urandom;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", {31'b0, out_valid}, 1);
      chk("out_data", out_data, e_out);
      chk("out_rd", {27'b0, out_rd}, {27'b0, r});
      chk("out_err", {31'b0, out_err}, {31'b0, e_err});
      chk("done_no_req", {31'b0, dmem_req}, 0);
      chk("done_in_ready", {31'b0, in_ready}, 0);
      if (h < hold) begin
        dmem_resp_valid = 1;
        dmem_rdata = $urandom;
        tick();
        dmem_resp_valid = 0;
      end
    end
    out_ready = 1;
    tick();
    chk("release_valid", {31'b0, out_valid}, 0);
    chk("release_ready", {31'b0, in_ready}, 1);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_req", {31'b0, dmem_req}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_err", {31'b0, out_err}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_strb", {28'b0, dmem_wstrb}, 0);
    run_op(2'd0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 0, 32'h0, 0);
    run_op(2'd1, 3'd0, 32'h0000_1003, 32'h0, 5'd7, 3, 32'h80FF_0011, 0);
    run_op(2'd1, 3'd4, 32'h0000_1003, 32'h0, 5'd7, 3, 32'h80FF_0011, 0);
    run_op(2'd2, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 5'd1, 2, 32'h0, 0);
    run_op(2'd1, 3'd2, 32'h0000_0006, 32'h0, 5'd2, 0, 32'h0, 0);
    run_op(2'd1, 3'd3, 32'h0000_0004, 32'h0, 5'd2, 0, 32'h0, 0);
    run_op(2'd1, 3'd5, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h8001_7FFE, 4);
    run_op(2'd3, 3'd2, 32'hDEAD_BEEF, 32'h0, 5'd31, 0, 32'h0, 0);
    in_valid = 1; in_kind = 2'd1; in_size = 3'd2; in_addr = 32'h0000_0040; in_rd = 5'd3;
    tick();
    in_valid = 0;
    chk("pre_rst_req", {31'b0, dmem_req}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_req", {31'b0, dmem_req}, 0);
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_ready", {31'b0, in_ready}, 1);
    chk("midrst_data", out_data, 0);
    dmem_resp_valid = 1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_resp_valid = 0;
    chk("late_resp_valid", {31'b0, out_valid}, 0);
    chk("late_resp_req", {31'b0, dmem_req}, 0);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      run_op(2'($urandom), sz, $urandom, $urandom, 5'($urandom), $urandom_range(0, 4),
             $urandom, $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute-to-memory path, directly downstream of the ALU. It takes the ALU result as either an effective address (loads/stores) or a plain result (non-memory ops) and drives a variable-latency data-memory request/response port. Loads are returned byte/half/word-extracted and sign- or zero-extended; stores get byte strobes. Results go to writeback through a valid/ready handshake.

## Interface
- No parameters; all widths fixed at 32-bit data/address.
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream op presented
- in_ready  output  1  unit can accept an op (high only in IDLE)
- in_addr  input  32  ALU result: effective address or pass-through value
- in_wdata  input  32  store data (rs2 value)
- in_kind  input  2  00 none (pass-through), 01 load, 10 store, 11 treated as none
- in_size  input  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; others illegal
- in_rd  input  5  destination register tag, passed through
- dmem_req  output  1  memory request, held until response
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word-aligned address ({in_addr[31:2],2'b00})
- dmem_wstrb  output  4  byte enables (0 for loads)
- dmem_wdata  output  32  lane-replicated store data
- dmem_resp_valid  input  1  one-cycle response/ack pulse
- dmem_rdata  input  32  read word, valid with dmem_resp_valid
- out_valid  output  1  result available
- out_ready  input  1  writeback accepts result
- out_data  output  32  extended load data, or latched in_addr for none/store/error
- out_rd  output  5  latched in_rd
- out_err  output  1  misaligned or illegal-size memory op

## Operation
- States: IDLE, REQ, DONE. Reset -> IDLE; all outputs 0 except in_ready=1.
- IDLE: on in_valid: latch addr, wdata, kind, size, rd.
  - kind none/11 -> DONE, out_data=in_addr, out_err=0.
  - memory op, illegal size, or misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE, out_err=1, out_data=in_addr, no memory request ever issued.
  - otherwise -> REQ.
- REQ: dmem_req=1, dmem_addr/we/wstrb/wdata stable for the whole state. On dmem_resp_valid -> DONE; load captures extracted data.
- Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. wdata: byte {4{b}}, half {2{h}}, word as-is.
- Load extract: shift dmem_rdata right by addr[1:0]*8, take low 8/16/32 bits; sizes 000/001 sign-extend from bit 7/15, 100/101 zero-extend.
- Store result: out_data=in_addr, out_err=0, completes on write ack.
- DONE: out_valid=1, outputs stable; out_valid&&out_ready -> IDLE.
- dmem_resp_valid outside REQ is ignored.

## Timing
- Accept in cycle T (in_valid&&in_ready). Non-memory or error: out_valid in T+1.
- Memory: dmem_req high from T+1; response in cycle R -> out_valid in R+1. Minimum load/store latency 2 cycles for same-cycle-ack memory (R=T+1).
- No new op accepted until the DONE->IDLE transition; in_ready rises the cycle after the out handshake. Throughput for pass-through ops: one per 2 cycles.
- out_ready low holds DONE indefinitely with out_* unchanged.
- rst in any state: next cycle IDLE, dmem_req=0, out_valid=0, out_err=0, outputs 0; a pending response arriving afterwards is ignored.
- Registered outputs only; no combinational path from in_* to dmem_* or out_*.

## Test plan
- Pass-through: kind=00, addr=0x1234_5678, rd=5, out_ready=1 -> out_valid one cycle later, out_data=0x1234_5678, out_rd=5, dmem_req never rises.
- Signed byte load: kind=01, size=000, addr=0x0000_1003, rdata=0x80FF_0011 after 3 wait cycles -> dmem_addr=0x0000_1000, wstrb=0, out_data=0xFFFF_FF80; size=100 same stimulus -> 0x0000_0080.
- Half store: kind=10, size=001, addr=0x2002, wdata=0x0000_ABCD -> dmem_we=1, wstrb=4'b1100, wdata=0xABCD_ABCD held until ack; out_err=0.
- Misaligned word load: addr=0x0000_0006, size=010 -> no dmem_req, out_err=1, out_data=0x0000_0006; size=011 -> out_err=1.
- Backpressure: complete a load with out_ready=0 for 4 cycles -> out_valid/out_data stable, in_ready=0; stray dmem_resp_valid during DONE ignored; release -> IDLE next cycle.
- Reset mid-request: assert rst while in REQ -> dmem_req=0 next cycle, later dmem_resp_valid produces no out_valid.
